// File: rtl/sr32_pkg.sv
// rtl/sr32_pkg.sv - shared types and widths for the sr32 shifter arbiter
package sr32_pkg;

  localparam int SHAMT_W = 5;
  localparam int CNT_W   = 16;
  localparam int PTR_W   = 2;

  typedef struct packed {
    logic [31:0]        data;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
  } shift_req_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority one-hot picker starting at ptr
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;

  // Walk distance k from ptr; the first eligible index reached wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && eligible[i] && (((int'(ptr) + k) % N) == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sr32.sv
// rtl/sr32.sv - combinational 32-bit logical/arithmetic right shifter
module sr32 (
  input  logic [31:0] in,
  input  logic [4:0]  shamt,
  input  logic        arithmetic,
  output logic [31:0] out
);

  assign out = arithmetic ? 32'($signed(in) >>> shamt) : (in >> shamt);

endmodule

// File: rtl/sr32_arbiter.sv
// rtl/sr32_arbiter.sv - round-robin sharing of one sr32 across N_REQ lanes
module sr32_arbiter
  import sr32_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_data,
  input  logic [N_REQ*5-1:0]   req_shamt,
  input  logic [N_REQ-1:0]     req_arith,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [N_REQ*W-1:0]   rsp_data,
  output logic [CNT_W-1:0]     grant_cnt
);

  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [N_REQ*W-1:0] rsp_data_q, rsp_data_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   slot_free;
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   pick;
  logic [N_REQ-1:0]   grant;
  shift_req_t         sel;
  logic [31:0]        shift_out;

  // A buffer being drained this cycle can take a new result at the same edge.
  assign slot_free = ~rsp_valid_q | rsp_ready;
  assign eligible  = req_valid & slot_free;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (pick)
  );

  assign grant     = pick & {N_REQ{n_rst}};
  assign req_ready = grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel.data  = req_data[W*i +: W];
        sel.shamt = req_shamt[SHAMT_W*i +: SHAMT_W];
        sel.arith = req_arith[i];
      end
    end
  end

  sr32 u_sr32 (
    .in         (sel.data),
    .shamt      (sel.shamt),
    .arithmetic (sel.arith),
    .out        (shift_out)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i]       = 1'b1;
        rsp_data_d[W*i +: W] = shift_out;
        ptr_d                = PTR_W'((i + 1) % N_REQ);
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
    if (|grant) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign grant_cnt = cnt_q;

  a_grant_onehot: assert property (@(posedge clk) $onehot0(req_ready));

  // A waiting requester must keep its request unchanged until accepted.
  for (genvar g = 0; g < N_REQ; g++) begin : g_stable
    a_req_stable: assert property (@(posedge clk) disable iff (!n_rst)
      (req_valid[g] && !req_ready[g]) |=>
        (req_valid[g] && $stable(req_data[W*g +: W]) &&
         $stable(req_shamt[SHAMT_W*g +: SHAMT_W]) && $stable(req_arith[g])));
  end

endmodule

// File: doc/sr32_arbiter.md
Name: sr32_arbiter

Overview:
Shares one combinational 32-bit right shifter (`sr32`: in, shamt, arithmetic -> out) between N_REQ requesters. Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin.
- The shifter result is captured into a per-requester one-entry response buffer.
- The block sits between the ALU issue logic and the shifter resource, so several execution lanes can use a single shifter.

Parameters:
N_REQ, 2, number of requesters (2..4); index 0..N_REQ-1.
W, 32, data width; fixed at 32 to match sr32.

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  synchronous active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester request accepted this cycle
req_data  input  N_REQ*32  operand per requester, slice [32*i +: 32]
req_shamt  input  N_REQ*5  shift amount per requester, slice [5*i +: 5]
req_arith  input  N_REQ  1 = arithmetic (sign fill), 0 = logical
rsp_valid  output  N_REQ  response buffer i holds a result
rsp_ready  input  N_REQ  consumer i takes the result this cycle
rsp_data  output  N_REQ*32  shifted result per requester
grant_cnt  output  16  total accepted requests, all requesters

Behaviour:
- Reset (n_rst=0 at a clk edge), taking priority over all other activity:
  - rsp_valid = 0, rsp_data = 0, grant_cnt = 0.
  - Priority pointer = 0.
  - In-flight buffers are discarded.
- Combinational signals:
  - slot_free[i] = !rsp_valid[i] || rsp_ready[i], so a buffer drained this cycle may be refilled in the same cycle.
  - eligible[i] = req_valid[i] && slot_free[i].
- Grant:
  - At most one grant per cycle, one-hot.
  - Search order starts at the priority pointer p: p, p+1, ... mod N_REQ.
  - The first eligible requester wins.
- req_ready = grant, combinational.
  - Depends on req_valid and rsp_ready.
  - No combinational path from req_data.
  - While n_rst=0, req_ready = 0.
- Shifter mux:
  - The single sr32 instance receives the granted requester's data, shamt and arith.
  - With no grant, its inputs are driven 0; its output is unused.
- On a clk edge with grant[i]:
  - rsp_data[i] <= sr32.out; rsp_valid[i] <= 1.
  - p <= (i+1) mod N_REQ.
  - grant_cnt <= grant_cnt + 1, wrapping 0xFFFF -> 0x0000.
- Buffer i not granted and rsp_ready[i]=1: rsp_valid[i] <= 0; rsp_data[i] holds its value.
- Latency and throughput:
  - Request accepted at edge N; result visible at rsp_valid/rsp_data after edge N.
  - One request per cycle aggregate.
  - Full per-requester throughput when the consumer keeps rsp_ready high.
- No grant in a cycle: p is unchanged.
- Backpressure: a full buffer with rsp_ready=0 makes requester i ineligible. The arbiter skips it and does not stall the others.
- Simultaneous fill and drain of the same buffer: the drain is honored and the new result loaded; rsp_valid stays 1.
- Request stability: req_* must hold stable while req_valid=1 && req_ready=0. This is a requester obligation; assertions check it.
- Shift semantics match sr32:
  - out = in >> shamt (logical) or arithmetic shift with in[31] fill.
  - shamt 0 passes the operand through; shamt 31 is the maximum.

Decomposition:
- Shared package sr32_pkg:
  - Typedef shift_req_t {logic [31:0] data; logic [4:0] shamt; logic arith;}.
  - Localparam SHAMT_W = 5.
  - Localparam CNT_W = 16.
- Sub-modules:
  - rr_pick (N_REQ-wide rotating-priority one-hot picker: inputs eligible and p; output grant) is a natural separate sub-module.
  - sr32 is instantiated unchanged.

Test Plan:
- Single request: req0 data=0x80000000, shamt=4, arith=1, rsp_ready=1 -> rsp_valid[0] for one cycle after accept; rsp_data[0]=0xF8000000; grant_cnt=1.
- Logical shift: req1 data=0x80000000, shamt=31, arith=0 -> rsp_data[1]=0x00000001. Then shamt=0, data=0x12345678 -> rsp_data[1]=0x12345678.
- Contention: both requesters valid every cycle, rsp_ready all 1, p=0 after reset -> grants alternate 0,1,0,1; each rsp_valid toggles; grant_cnt=8 after 8 cycles.
- Backpressure: rsp_ready[0]=0 with buffer 0 full and both requesting -> req_ready[0]=0 and requester 1 granted every cycle. Raising rsp_ready[0] -> req0 granted in that same cycle; rsp_valid[0] stays 1 with new data next cycle.
- Reset mid-operation: both buffers full with rsp_ready=0; assert n_rst=0 for one edge -> rsp_valid=0, rsp_data=0, grant_cnt=0, req_ready=0. After release, the first contended grant goes to requester 0.
- Counter wrap: preload via 65535 accepted requests, then one more -> grant_cnt=0x0000.
